// File: rtl/hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit
//
// Decode-stage pipeline controller, placed directly upstream of forwarding_unit.
// Handles the hazards that operand forwarding cannot resolve:
//   - load-use          : load in EX, consumer in ID            (cause 01)
//   - branch-after-load : load in MEM, ID-compared branch in ID  (cause 10)
//   - data-memory wait  : whole pipe frozen while dmem not ready (cause 11)
// It also holds fetch for RESET_HOLD cycles after reset release and runs a
// watchdog over consecutive data-memory stall cycles.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add three stall-cause
// performance counters (o_cnt_load_use, o_cnt_branch_load, o_cnt_dmem).
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_if_id_*             instruction in ID: valid, rs1/rs2, rs use flags,
//                         branch-compared-in-ID flag
//   i_branch_taken        ID branch resolved taken this cycle
//   i_id_ex_mem_read/rd   instruction in EX is a load / its destination
//   i_ex_mem_mem_read/rd  instruction in MEM is a load / its destination
//   i_dmem_stall          data memory not ready this cycle
//   o_pc_write            PC update enable
//   o_if_id_write         IF/ID register enable
//   o_if_id_flush         squash IF/ID on a taken branch
//   o_id_ex_bubble        load a NOP into ID/EX
//   o_freeze              hold ID/EX, EX/MEM, MEM/WB
//   o_stall_cause         00 none, 01 load-use, 10 branch-load, 11 dmem/reset
//   o_freeze_timeout      sticky watchdog flag, cleared only by reset
//   o_cnt_*               per-cause stall-cycle counters (optional)
// -----------------------------------------------------------------------------
`default_nettype none

module hazard_detection_unit #(
    parameter int unsigned NB_OPERAND = 5,
    parameter int unsigned RESET_HOLD = 4,
    parameter int unsigned MAX_FREEZE = 255
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned NB_CNT     = 32
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_id_valid,
    input  logic [NB_OPERAND-1:0] i_if_id_rs1,
    input  logic [NB_OPERAND-1:0] i_if_id_rs2,
    input  logic                  i_if_id_use_rs1,
    input  logic                  i_if_id_use_rs2,
    input  logic                  i_if_id_is_branch,
    input  logic                  i_branch_taken,
    input  logic                  i_id_ex_mem_read,
    input  logic [NB_OPERAND-1:0] i_id_ex_rd,
    input  logic                  i_ex_mem_mem_read,
    input  logic [NB_OPERAND-1:0] i_ex_mem_rd,
    input  logic                  i_dmem_stall,
    output logic                  o_pc_write,
    output logic                  o_if_id_write,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_bubble,
    output logic                  o_freeze,
    output logic [1:0]            o_stall_cause,
    output logic                  o_freeze_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [NB_CNT-1:0]     o_cnt_load_use,
    output logic [NB_CNT-1:0]     o_cnt_branch_load,
    output logic [NB_CNT-1:0]     o_cnt_dmem
`endif
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int unsigned      FRZ_W     = $clog2(MAX_FREEZE + 1);
    localparam logic [FRZ_W-1:0] FRZ_MAX   = FRZ_W'(MAX_FREEZE);
    localparam logic [FRZ_W-1:0] FRZ_ONE   = FRZ_W'(1);
    localparam logic [3:0]       HOLD_INIT = 4'(RESET_HOLD - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_LU   = 2'b01;
    localparam logic [1:0] CAUSE_BL   = 2'b10;
    localparam logic [1:0] CAUSE_DMEM = 2'b11;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_FREEZE
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [3:0]       hold_q, hold_d;
    logic [FRZ_W-1:0] frz_q, frz_d;
    logic             timeout_q, timeout_d;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    // A producer only matters if it writes a real register and the valid
    // instruction in ID actually reads that register through a used port.
    function automatic logic rd_match(
        input logic [NB_OPERAND-1:0] rd,
        input logic                  valid,
        input logic                  use_rs1,
        input logic [NB_OPERAND-1:0] rs1,
        input logic                  use_rs2,
        input logic [NB_OPERAND-1:0] rs2
    );
        return (rd != '0) && valid &&
               ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
    endfunction

    logic lu_hit;
    logic bl_hit;

    assign lu_hit = i_id_ex_mem_read &&
                    rd_match(i_id_ex_rd, i_if_id_valid, i_if_id_use_rs1, i_if_id_rs1,
                             i_if_id_use_rs2, i_if_id_rs2);

    // Only branches compared in ID need the loaded value a stage early; ALU
    // results sitting in EX/MEM are handled by forwarding_unit.
    assign bl_hit = i_if_id_is_branch && i_ex_mem_mem_read &&
                    rd_match(i_ex_mem_rd, i_if_id_valid, i_if_id_use_rs1, i_if_id_rs1,
                             i_if_id_use_rs2, i_if_id_rs2);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        frz_d     = frz_q;
        timeout_d = timeout_q;

        unique case (state_q)
            S_HOLD: begin
                if (hold_q == 4'd0) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            S_RUN: begin
                // The cycle that enters the freeze is itself the first stall
                // cycle, so the watchdog starts counting at one.
                if (i_dmem_stall) begin
                    state_d = S_FREEZE;
                    frz_d   = FRZ_ONE;
                end
            end
            S_FREEZE: begin
                if (i_dmem_stall) begin
                    if (frz_q != FRZ_MAX) begin
                        frz_d = frz_q + FRZ_ONE;
                    end
                end else begin
                    state_d = S_RUN;
                    frz_d   = '0;
                end
            end
            default: begin
                state_d = S_HOLD;
                hold_d  = HOLD_INIT;
                frz_d   = '0;
            end
        endcase

        // Flag only; the freeze itself is kept until memory is ready.
        if ((state_q != S_HOLD) && i_dmem_stall && (frz_d == FRZ_MAX)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_HOLD;
            hold_q    <= HOLD_INIT;
            frz_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            frz_q     <= frz_d;
            timeout_q <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    // RUN and FREEZE share one priority decode: in FREEZE with memory ready the
    // outputs are already those of RUN on that same cycle. A taken branch is
    // dropped under any stall; it stays in ID and resolves again later.
    always_comb begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b1;
        o_freeze       = 1'b0;
        o_stall_cause  = CAUSE_DMEM;

        if (state_q != S_HOLD) begin
            if (i_dmem_stall) begin
                o_id_ex_bubble = 1'b0;
                o_freeze       = 1'b1;
                o_stall_cause  = CAUSE_DMEM;
            end else if (lu_hit) begin
                o_stall_cause  = CAUSE_LU;
            end else if (bl_hit) begin
                o_stall_cause  = CAUSE_BL;
            end else begin
                o_pc_write     = 1'b1;
                o_if_id_write  = 1'b1;
                o_if_id_flush  = i_branch_taken;
                o_id_ex_bubble = 1'b0;
                o_stall_cause  = CAUSE_NONE;
            end
        end
    end

    assign o_freeze_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Stall-cause performance counters (wrap naturally)
    // -------------------------------------------------------------------------
    localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);

    logic [NB_CNT-1:0] cnt_lu_q, cnt_lu_d;
    logic [NB_CNT-1:0] cnt_bl_q, cnt_bl_d;
    logic [NB_CNT-1:0] cnt_dm_q, cnt_dm_d;

    always_comb begin
        cnt_lu_d = cnt_lu_q;
        cnt_bl_d = cnt_bl_q;
        cnt_dm_d = cnt_dm_q;
        // Cause 11 during the post-reset hold is not a memory stall.
        if (state_q != S_HOLD) begin
            unique case (o_stall_cause)
                CAUSE_LU:   cnt_lu_d = cnt_lu_q + CNT_ONE;
                CAUSE_BL:   cnt_bl_d = cnt_bl_q + CNT_ONE;
                CAUSE_DMEM: cnt_dm_d = cnt_dm_q + CNT_ONE;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_lu_q <= '0;
            cnt_bl_q <= '0;
            cnt_dm_q <= '0;
        end else begin
            cnt_lu_q <= cnt_lu_d;
            cnt_bl_q <= cnt_bl_d;
            cnt_dm_q <= cnt_dm_d;
        end
    end

    assign o_cnt_load_use    = cnt_lu_q;
    assign o_cnt_branch_load = cnt_bl_q;
    assign o_cnt_dmem        = cnt_dm_q;
`endif

endmodule

`default_nettype wire
